// File: rtl/tx_keying_sequencer_if.sv
// Control/status bundle between host/keyer logic and the transmit keying sequencer.
interface tx_keying_sequencer_if;
    logic        ptt_req;
    logic        cw_key;
    logic [15:0] cw_level;
    logic [15:0] hang_time;
    logic        tx_fifo_empty;
    logic        clr_underrun;
    logic        relay_out;
    logic        tx_ptt;
    logic        cw_ptt;
    logic [15:0] cw_rf;
    logic        underrun;
    logic [2:0]  state;

    modport master (
        output ptt_req, cw_key, cw_level, hang_time, tx_fifo_empty, clr_underrun,
        input  relay_out, tx_ptt, cw_ptt, cw_rf, underrun, state
    );

    modport slave (
        input  ptt_req, cw_key, cw_level, hang_time, tx_fifo_empty, clr_underrun,
        output relay_out, tx_ptt, cw_ptt, cw_rf, underrun, state
    );
endinterface

// File: rtl/tx_keying_sequencer.sv
// Transmit keying sequencer: arbitrates PTT/CW, sequences the T/R relay with guard
// delays, shapes the CW envelope and aborts SSB on a prolonged FIFO underrun.
module tx_keying_sequencer #(
    parameter int unsigned RELAY_DLY    = 3840,
    parameter int unsigned RAMP_DIV     = 60,
    parameter int unsigned RAMP_STEP    = 256,
    parameter int unsigned UNDERRUN_MAX = 4800
) (
    input  logic                 clk,
    input  logic                 reset,
    tx_keying_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RELAY_WAIT   = 3'd1,
        SSB_TX       = 3'd2,
        CW_RAMP_UP   = 3'd3,
        CW_ON        = 3'd4,
        CW_RAMP_DOWN = 3'd5,
        CW_HANG      = 3'd6,
        RELEASE      = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   ucnt_q, ucnt_d;
    logic [15:0]        cw_rf_q, cw_rf_d;
    logic               mode_cw_q, mode_cw_d;
    logic               lockout_q, lockout_d;
    logic               underrun_q, underrun_d;
    logic               relay_q, tx_ptt_q, cw_ptt_q;

    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   hang_lim;
    logic [16:0]        up_sum;
    logic               step_due;
    logic               set_underrun;

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign hang_lim = CNT_W'({bus.hang_time, 10'b0});
    assign up_sum   = 17'(cw_rf_q) + 17'(RAMP_STEP);
    assign step_due = (div_q == CNT_W'(RAMP_DIV - 1));

    // State and datapath registers; gate outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            ucnt_q     <= '0;
            cw_rf_q    <= '0;
            mode_cw_q  <= 1'b0;
            lockout_q  <= 1'b0;
            underrun_q <= 1'b0;
            relay_q    <= 1'b0;
            tx_ptt_q   <= 1'b0;
            cw_ptt_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            ucnt_q     <= ucnt_d;
            cw_rf_q    <= cw_rf_d;
            mode_cw_q  <= mode_cw_d;
            lockout_q  <= lockout_d;
            underrun_q <= underrun_d;
            relay_q    <= (state_d != IDLE);
            tx_ptt_q   <= (state_d inside {SSB_TX, CW_RAMP_UP, CW_ON, CW_RAMP_DOWN, CW_HANG});
            cw_ptt_q   <= (state_d inside {CW_RAMP_UP, CW_ON, CW_RAMP_DOWN, CW_HANG});
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        ucnt_d       = '0;
        cw_rf_d      = cw_rf_q;
        mode_cw_d    = mode_cw_q;
        lockout_d    = lockout_q;
        set_underrun = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.cw_key) begin
                    state_d   = RELAY_WAIT;
                    mode_cw_d = 1'b1;
                end else if (bus.ptt_req && !lockout_q) begin
                    state_d   = RELAY_WAIT;
                    mode_cw_d = 1'b0;
                end
                if (!bus.ptt_req) lockout_d = 1'b0;
            end
            RELAY_WAIT: begin
                div_d = '0;
                if (cnt_q == CNT_W'(RELAY_DLY - 1)) begin
                    cnt_d = '0;
                    if (mode_cw_q) state_d = bus.cw_key  ? CW_RAMP_UP : CW_HANG;
                    else           state_d = bus.ptt_req ? SSB_TX     : RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SSB_TX: begin
                if (!bus.ptt_req) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else if (bus.tx_fifo_empty) begin
                    if (ucnt_q == CNT_W'(UNDERRUN_MAX - 1)) begin
                        set_underrun = 1'b1;
                        lockout_d    = 1'b1;
                        state_d      = RELEASE;
                        cnt_d        = '0;
                    end else begin
                        ucnt_d = ucnt_q + CNT_W'(1);
                    end
                end
            end
            CW_RAMP_UP: begin
                if (!bus.cw_key) begin
                    state_d = CW_RAMP_DOWN;
                    div_d   = '0;
                end else if (cw_rf_q >= bus.cw_level) begin
                    cw_rf_d = bus.cw_level;
                    state_d = CW_ON;
                end else if (step_due) begin
                    div_d = '0;
                    if (up_sum >= {1'b0, bus.cw_level}) begin
                        cw_rf_d = bus.cw_level;
                        state_d = CW_ON;
                    end else begin
                        cw_rf_d = up_sum[15:0];
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            CW_ON: begin
                if (!bus.cw_key) begin
                    state_d = CW_RAMP_DOWN;
                    div_d   = '0;
                end else begin
                    cw_rf_d = bus.cw_level;
                end
            end
            CW_RAMP_DOWN: begin
                if (bus.cw_key) begin
                    state_d = CW_RAMP_UP;
                    div_d   = '0;
                end else if (cw_rf_q == 16'd0) begin
                    state_d = CW_HANG;
                    cnt_d   = '0;
                end else if (step_due) begin
                    div_d = '0;
                    if (cw_rf_q <= 16'(RAMP_STEP)) begin
                        cw_rf_d = '0;
                        state_d = CW_HANG;
                        cnt_d   = '0;
                    end else begin
                        cw_rf_d = cw_rf_q - 16'(RAMP_STEP);
                    end
                end else begin
                    div_d = div_q + CNT_W'(1);
                end
            end
            CW_HANG: begin
                if (bus.cw_key) begin
                    state_d = CW_RAMP_UP;
                    div_d   = '0;
                    cnt_d   = '0;
                    cw_rf_d = '0;
                end else if (cnt_inc >= hang_lim) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (cnt_q == CNT_W'(RELAY_DLY - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Envelope is only live while ramping or keyed on.
        if (!(state_d inside {CW_RAMP_UP, CW_ON, CW_RAMP_DOWN})) cw_rf_d = '0;

        // A same-cycle set wins over clear.
        underrun_d = set_underrun | (underrun_q & ~bus.clr_underrun);
    end

    assign bus.relay_out = relay_q;
    assign bus.tx_ptt    = tx_ptt_q;
    assign bus.cw_ptt    = cw_ptt_q;
    assign bus.cw_rf     = cw_rf_q;
    assign bus.underrun  = underrun_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_tx_keying_sequencer.sv
// Directed self-checking bench for tx_keying_sequencer with shortened timing parameters.
module tb_tx_keying_sequencer;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    tx_keying_sequencer_if bus ();

    tx_keying_sequencer #(
        .RELAY_DLY   (8),
        .RAMP_DIV    (2),
        .RAMP_STEP   (1000),
        .UNDERRUN_MAX(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cycles);
        int n = 0;
        while (bus.state != 3'd0 && n < max_cycles) begin
            tick(1);
            n++;
        end
        check(tag, 32'(bus.state), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.ptt_req       = 1'b0;
        bus.cw_key        = 1'b0;
        bus.cw_level      = 16'd0;
        bus.hang_time     = 16'd0;
        bus.tx_fifo_empty = 1'b0;
        bus.clr_underrun  = 1'b0;
        tick(3);
        check("rst_state", 32'(bus.state), 0);
        check("rst_relay", 32'(bus.relay_out), 0);
        check("rst_cw_rf", 32'(bus.cw_rf), 0);
        check("rst_underrun", 32'(bus.underrun), 0);
        reset = 1'b0;
        tick(2);

        // 1: SSB keying and release timing
        bus.ptt_req = 1'b1;
        tick(1);
        check("ssb_relay_up", 32'(bus.relay_out), 1);
        check("ssb_wait_state", 32'(bus.state), 1);
        check("ssb_ptt_early", 32'(bus.tx_ptt), 0);
        tick(7);
        check("ssb_ptt_edge8", 32'(bus.tx_ptt), 0);
        tick(1);
        check("ssb_ptt_edge9", 32'(bus.tx_ptt), 1);
        check("ssb_state", 32'(bus.state), 2);
        check("ssb_cw_ptt", 32'(bus.cw_ptt), 0);
        bus.ptt_req = 1'b0;
        tick(1);
        check("ssb_rel_ptt", 32'(bus.tx_ptt), 0);
        check("ssb_rel_state", 32'(bus.state), 7);
        tick(7);
        check("ssb_rel_hold", 32'(bus.relay_out), 1);
        tick(1);
        check("ssb_rel_relay", 32'(bus.relay_out), 0);
        check("ssb_rel_idle", 32'(bus.state), 0);

        // 2: CW ramp up, ramp down, hang, release
        bus.cw_level  = 16'd4000;
        bus.hang_time = 16'd1;
        bus.cw_key    = 1'b1;
        tick(9);
        check("cw_up_state", 32'(bus.state), 3);
        check("cw_up_cw_ptt", 32'(bus.cw_ptt), 1);
        check("cw_up_rf0", 32'(bus.cw_rf), 0);
        for (int i = 1; i <= 4; i++) begin
            tick(2);
            check("cw_up_rf", 32'(bus.cw_rf), 32'(i * 1000));
        end
        check("cw_on_state", 32'(bus.state), 4);
        check("cw_on_cw_ptt", 32'(bus.cw_ptt), 1);
        bus.cw_key = 1'b0;
        tick(1);
        check("cw_dn_state", 32'(bus.state), 5);
        for (int i = 3; i >= 0; i--) begin
            tick(2);
            check("cw_dn_rf", 32'(bus.cw_rf), 32'(i * 1000));
        end
        check("cw_hang_state", 32'(bus.state), 6);
        check("cw_hang_tx_ptt", 32'(bus.tx_ptt), 1);
        tick(1023);
        check("cw_hang_end", 32'(bus.state), 6);
        tick(1);
        check("cw_release", 32'(bus.state), 7);
        check("cw_release_ptt", 32'(bus.cw_ptt), 0);
        tick(8);
        check("cw_idle", 32'(bus.state), 0);

        // 3: key re-pressed during hang
        bus.cw_level = 16'd1000;
        bus.cw_key   = 1'b1;
        tick(11);
        check("rk_on", 32'(bus.state), 4);
        bus.cw_key = 1'b0;
        tick(3);
        check("rk_hang", 32'(bus.state), 6);
        tick(100);
        bus.cw_key = 1'b1;
        tick(1);
        check("rk_up_state", 32'(bus.state), 3);
        check("rk_up_relay", 32'(bus.relay_out), 1);
        check("rk_up_rf0", 32'(bus.cw_rf), 0);
        tick(2);
        check("rk_up_rf", 32'(bus.cw_rf), 1000);
        check("rk_up_relay2", 32'(bus.relay_out), 1);
        bus.cw_key    = 1'b0;
        bus.hang_time = 16'd0;
        tick(4);
        check("rk_hang0_release", 32'(bus.state), 7);
        wait_idle("rk_idle", 20);

        // 4: underrun abort, lockout and clear
        bus.ptt_req = 1'b1;
        tick(9);
        check("ur_ssb", 32'(bus.state), 2);
        bus.tx_fifo_empty = 1'b1;
        tick(15);
        bus.tx_fifo_empty = 1'b0;
        tick(1);
        check("ur_15_state", 32'(bus.state), 2);
        check("ur_15_flag", 32'(bus.underrun), 0);
        bus.tx_fifo_empty = 1'b1;
        bus.clr_underrun  = 1'b1;
        tick(15);
        check("ur_pre_state", 32'(bus.state), 2);
        tick(1);
        check("ur_abort_state", 32'(bus.state), 7);
        check("ur_set_over_clr", 32'(bus.underrun), 1);
        check("ur_abort_ptt", 32'(bus.tx_ptt), 0);
        bus.clr_underrun  = 1'b0;
        bus.tx_fifo_empty = 1'b0;
        tick(8);
        check("ur_idle", 32'(bus.state), 0);
        tick(5);
        check("ur_lockout", 32'(bus.state), 0);
        check("ur_sticky", 32'(bus.underrun), 1);
        bus.ptt_req = 1'b0;
        tick(1);
        bus.ptt_req = 1'b1;
        tick(1);
        check("ur_restart", 32'(bus.state), 1);
        bus.clr_underrun = 1'b1;
        tick(1);
        check("ur_clear", 32'(bus.underrun), 0);
        bus.clr_underrun = 1'b0;
        bus.ptt_req      = 1'b0;
        wait_idle("ur_end_idle", 30);

        // 5: asynchronous reset mid CW_ON
        bus.cw_level = 16'd1000;
        bus.cw_key   = 1'b1;
        tick(11);
        check("ar_on", 32'(bus.state), 4);
        #2;
        reset = 1'b1;
        #1;
        check("ar_state", 32'(bus.state), 0);
        check("ar_relay", 32'(bus.relay_out), 0);
        check("ar_tx_ptt", 32'(bus.tx_ptt), 0);
        check("ar_cw_ptt", 32'(bus.cw_ptt), 0);
        check("ar_cw_rf", 32'(bus.cw_rf), 0);
        bus.cw_key = 1'b0;
        #1;
        reset = 1'b0;
        tick(1);
        check("ar_idle", 32'(bus.state), 0);

        // 6: priority and clamping
        bus.cw_level = 16'd2500;
        bus.cw_key   = 1'b1;
        bus.ptt_req  = 1'b1;
        tick(9);
        check("pr_cw_mode", 32'(bus.state), 3);
        tick(2);
        check("cl_rf1", 32'(bus.cw_rf), 1000);
        tick(2);
        check("cl_rf2", 32'(bus.cw_rf), 2000);
        tick(2);
        check("cl_rf3", 32'(bus.cw_rf), 2500);
        check("cl_on", 32'(bus.state), 4);
        bus.cw_level = 16'd1200;
        tick(1);
        check("cl_live", 32'(bus.cw_rf), 1200);
        bus.cw_key  = 1'b0;
        bus.ptt_req = 1'b0;
        tick(3);
        check("cl_dn_rf", 32'(bus.cw_rf), 200);
        tick(2);
        check("cl_dn_zero", 32'(bus.cw_rf), 0);
        check("cl_hang", 32'(bus.state), 6);
        wait_idle("cl_idle", 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
